// File: rtl/cpu_control_if.sv
// Memory-side bus of the 4-bit CPU controller.
// The controller drives the address, strobes and write data.
// The 16x4 memory returns combinational read data for the current address.
interface cpu_control_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_rd_en_o;
    logic                  mem_wr_en_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic [DATA_WIDTH-1:0] mem_data_i;

    modport master (
        output mem_addr_o,
        output mem_rd_en_o,
        output mem_wr_en_o,
        output mem_data_o,
        input  mem_data_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_rd_en_o,
        input  mem_wr_en_o,
        input  mem_data_o,
        output mem_data_i
    );
endinterface

// File: rtl/cpu_control.sv
// Fetch/decode/execute controller for the 4-bit CPU.
// It owns PC, accumulator, IR/OPR/MDR and the Z/C flags.
// It sequences FETCH -> [OPERAND -> [MEMACC]] -> [EXEC] against a 16x4
// memory whose read data is combinational from the address.
module cpu_control #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  run_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    cpu_control_if.master         bus,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] acc_o
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_OPERAND = 2'd1;
    localparam logic [1:0] S_MEMACC  = 2'd2;
    localparam logic [1:0] S_EXEC    = 2'd3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_XOR = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_INC = 4'h5;
    localparam logic [3:0] OP_DEC = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_LD  = 4'hB;
    localparam logic [3:0] OP_ST  = 4'hC;
    localparam logic [3:0] OP_IN  = 4'hD;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_LDI = 4'hF;

    logic [1:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
    logic [DATA_WIDTH-1:0] a_q,        a_d;
    logic [DATA_WIDTH-1:0] ir_q,       ir_d;
    logic [DATA_WIDTH-1:0] opr_q,      opr_d;
    logic [DATA_WIDTH-1:0] mdr_q,      mdr_d;
    logic                  z_q,        z_d;
    logic                  c_q,        c_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    // Opcodes that are followed by an operand nibble.
    function automatic logic hasOperand(input logic [DATA_WIDTH-1:0] op);
        return !(op inside {OP_NOP, OP_INC, OP_DEC, OP_IN, OP_OUT});
    endfunction

    // Operand-carrying opcodes whose operand is a direct memory address.
    function automatic logic needsMemAccess(input logic [DATA_WIDTH-1:0] op);
        return op inside {OP_XOR, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_LD, OP_ST};
    endfunction

    assign bus.mem_data_o = a_q;
    assign out_data_o     = out_data_q;
    assign out_valid_o    = out_valid_q;
    assign pc_o           = pc_q;
    assign acc_o          = a_q;

    // Next-state, datapath and memory-strobe decode for the current phase.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        a_d             = a_q;
        ir_d            = ir_q;
        opr_d           = opr_q;
        mdr_d           = mdr_q;
        z_d             = z_q;
        c_d             = c_q;
        out_data_d      = out_data_q;
        out_valid_d     = 1'b0;
        bus.mem_addr_o  = pc_q;
        bus.mem_rd_en_o = 1'b0;
        bus.mem_wr_en_o = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run_i) begin
                    bus.mem_rd_en_o = 1'b1;
                    ir_d            = bus.mem_data_i;
                    pc_d            = pc_q + ADDR_WIDTH'(1);
                    state_d         = hasOperand(bus.mem_data_i) ? S_OPERAND : S_EXEC;
                end
            end
            S_OPERAND: begin
                bus.mem_rd_en_o = 1'b1;
                opr_d           = bus.mem_data_i;
                pc_d            = pc_q + ADDR_WIDTH'(1);
                state_d         = needsMemAccess(ir_q) ? S_MEMACC : S_EXEC;
            end
            S_MEMACC: begin
                bus.mem_addr_o = opr_q;
                if (ir_q == OP_ST) begin
                    bus.mem_wr_en_o = 1'b1;
                    state_d         = S_FETCH;
                end else begin
                    bus.mem_rd_en_o = 1'b1;
                    mdr_d           = bus.mem_data_i;
                    state_d         = S_EXEC;
                end
            end
            default: begin
                state_d = S_FETCH;
                case (ir_q)
                    OP_XOR: begin a_d = a_q ^ mdr_q; c_d = 1'b0; end
                    OP_AND: begin a_d = a_q & mdr_q; c_d = 1'b0; end
                    OP_OR:  begin a_d = a_q | mdr_q; c_d = 1'b0; end
                    OP_ADD: {c_d, a_d} = {1'b0, a_q} + {1'b0, mdr_q};
                    OP_SUB: begin
                        c_d = (a_q < mdr_q);
                        a_d = a_q - mdr_q;
                    end
                    OP_INC: begin
                        c_d = (a_q == {DATA_WIDTH{1'b1}});
                        a_d = a_q + DATA_WIDTH'(1);
                    end
                    OP_DEC: begin
                        c_d = (a_q == '0);
                        a_d = a_q - DATA_WIDTH'(1);
                    end
                    OP_JMP: pc_d = opr_q;
                    OP_JZ:  if (z_q) pc_d = opr_q;
                    OP_JC:  if (c_q) pc_d = opr_q;
                    OP_LD:  a_d = mdr_q;
                    OP_IN:  a_d = in_data_i;
                    OP_LDI: a_d = opr_q;
                    OP_OUT: begin
                        out_data_d  = a_q;
                        out_valid_d = 1'b1;
                    end
                    default: ;
                endcase
                if (ir_q inside {OP_XOR, OP_AND, OP_OR, OP_ADD, OP_SUB, OP_INC,
                                 OP_DEC, OP_LD, OP_IN, OP_LDI}) begin
                    z_d = (a_d == '0);
                end
            end
        endcase
    end

    // Architectural state, cleared asynchronously so a reset aborts any phase.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            a_q         <= '0;
            ir_q        <= '0;
            opr_q       <= '0;
            mdr_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            ir_q        <= ir_d;
            opr_q       <= opr_d;
            mdr_q       <= mdr_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: a 16x4 memory on the bus.
// An instruction-level reference model predicts the outcome of each instruction.
// Directed programs and random programs are run against the design.
module tb_cpu_control;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       run = 1'b0;
    logic [3:0] inData = 4'h0;
    logic [3:0] outData;
    logic       outValid;
    logic [3:0] pcObs;
    logic [3:0] accObs;

    cpu_control_if bus ();

    cpu_control dut (
        .clk_i       (clk),
        .reset_ni    (resetN),
        .run_i       (run),
        .in_data_i   (inData),
        .bus         (bus),
        .out_data_o  (outData),
        .out_valid_o (outValid),
        .pc_o        (pcObs),
        .acc_o       (accObs)
    );

    always #5 clk = ~clk;

    logic [3:0] tbMem [16];
    logic [3:0] progImage [16];
    logic       loadReq = 1'b0;

    // Memory: bulk load on request, otherwise commit CPU writes on the clock edge.
    always @(posedge clk) begin
        if (loadReq) tbMem <= progImage;
        else if (bus.mem_wr_en_o) tbMem[bus.mem_addr_o] <= bus.mem_data_o;
    end

    assign bus.mem_data_i = tbMem[bus.mem_addr_o];

    int checks = 0;
    int errors = 0;

    // Reference model state at instruction granularity.
    int mMem [16];
    int mA, mPc, mOut;
    bit mZ, mC;

    int         lastWrCount;
    logic [3:0] lastWrAddr;
    logic [3:0] lastWrData;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setImage(input logic [63:0] img);
        for (int i = 0; i < 16; i++) progImage[i] = img[63 - 4*i -: 4];
    endtask

    task automatic doReset(input bit runAfter);
        resetN  = 1'b0;
        run     = 1'b0;
        loadReq = 1'b1;
        @(posedge clk);
        #1;
        loadReq = 1'b0;
        for (int i = 0; i < 16; i++) mMem[i] = int'(progImage[i]);
        mA = 0; mPc = 0; mOut = 0; mZ = 0; mC = 0;
        resetN = 1'b1;
        run    = runAfter;
    endtask

    // Execute one instruction in the model: returns opcode, operand and cycle cost.
    task automatic modelStep(input int inVal, output int op, output int opr, output int cycles);
        op  = mMem[mPc];
        mPc = (mPc + 1) % 16;
        opr = 0;
        if (op inside {0, 5, 6, 13, 14}) cycles = 2;
        else if (op inside {8, 9, 10, 12, 15}) cycles = 3;
        else cycles = 4;
        if (!(op inside {0, 5, 6, 13, 14})) begin
            opr = mMem[mPc];
            mPc = (mPc + 1) % 16;
        end
        case (op)
            1:  begin mA = mA ^ mMem[opr]; mC = 0; end
            2:  begin mA = mA & mMem[opr]; mC = 0; end
            3:  begin mA = mA | mMem[opr]; mC = 0; end
            4:  begin mC = (mA + mMem[opr]) > 15; mA = (mA + mMem[opr]) % 16; end
            5:  begin mC = (mA == 15); mA = (mA + 1) % 16; end
            6:  begin mC = (mA == 0); mA = (mA + 15) % 16; end
            7:  begin mC = (mA < mMem[opr]); mA = (mA - mMem[opr] + 16) % 16; end
            8:  mPc = opr;
            9:  if (mZ) mPc = opr;
            10: if (mC) mPc = opr;
            11: mA = mMem[opr];
            12: mMem[opr] = mA;
            13: mA = inVal;
            14: mOut = mA;
            15: mA = opr;
            default: ;
        endcase
        if (op inside {1, 2, 3, 4, 5, 6, 7, 11, 13, 15}) mZ = (mA == 0);
    endtask

    // Run one whole instruction on the DUT and compare it with the model.
    task automatic applyStimulus(input bit randomRun);
        int op, opr, cycles, stA;
        inData = 4'($urandom);
        #1;
        checkOutput("fetchAddr", 16'(bus.mem_addr_o), 16'(mPc));
        checkOutput("fetchRdEn", 16'(bus.mem_rd_en_o), 16'd1);
        stA = mA;
        modelStep(int'(inData), op, opr, cycles);
        lastWrCount = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.mem_wr_en_o === 1'b1) begin
                lastWrCount++;
                lastWrAddr = bus.mem_addr_o;
                lastWrData = bus.mem_data_o;
            end
            @(posedge clk);
            #1;
            if (randomRun && i == 0) run = 1'($urandom);
        end
        run = 1'b1;
        checkOutput("pc", 16'(pcObs), 16'(mPc));
        checkOutput("acc", 16'(accObs), 16'(mA));
        checkOutput("outValid", 16'(outValid), 16'(op == 14));
        checkOutput("outData", 16'(outData), 16'(mOut));
        checkOutput("wrCount", 16'(lastWrCount), 16'(op == 12));
        if (op == 12) begin
            checkOutput("wrAddr", 16'(lastWrAddr), 16'(opr));
            checkOutput("wrData", 16'(lastWrData), 16'(stA));
        end
    endtask

    task automatic stallCycles(input int n);
        run = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stallPc", 16'(pcObs), 16'(mPc));
            checkOutput("stallRdEn", 16'(bus.mem_rd_en_o), 16'd0);
        end
        run = 1'b1;
    endtask

    initial begin
        int waited;

        // Reset state and idle with run low; program is OUT, INC, JMP 0.
        setImage(64'hE580_0000_0000_0000);
        doReset(1'b0);
        checkOutput("resetPc", 16'(pcObs), 16'd0);
        checkOutput("resetAcc", 16'(accObs), 16'd0);
        checkOutput("resetOutValid", 16'(outValid), 16'd0);
        checkOutput("resetOutData", 16'(outData), 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idlePc", 16'(pcObs), 16'd0);
            checkOutput("idleRdEn", 16'(bus.mem_rd_en_o), 16'd0);
        end
        run = 1'b1;
        #1;
        checkOutput("firstFetchRdEn", 16'(bus.mem_rd_en_o), 16'd1);
        checkOutput("firstFetchAddr", 16'(bus.mem_addr_o), 16'd0);

        // Counter program: one OUT pulse every 7 cycles, values 0..15 then 0.
        for (int k = 0; k < 17; k++) begin
            waited = 0;
            do begin
                @(posedge clk);
                #1;
                waited++;
            end while (outValid !== 1'b1 && waited < 20);
            checkOutput("outPulse", 16'(outValid), 16'd1);
            checkOutput("outValue", 16'(outData), 16'(k % 16));
            checkOutput("outSpacing", 16'(waited), (k == 0) ? 16'd2 : 16'd7);
        end

        // LDI 9, ADD @E(8), JZ 0, JC 8, SUB @F(1), JC 0, JZ 0.
        $display("[TB] arithmetic and conditional jumps");
        setImage(64'hF94E_90A8_7FA0_9081);
        doReset(1'b1);
        applyStimulus(1'b0);
        checkOutput("ldiAcc", 16'(accObs), 16'd9);
        applyStimulus(1'b0);
        checkOutput("addAcc", 16'(accObs), 16'd1);
        applyStimulus(1'b0);
        checkOutput("jzNotTakenPc", 16'(pcObs), 16'd6);
        applyStimulus(1'b0);
        checkOutput("jcTakenPc", 16'(pcObs), 16'd8);
        applyStimulus(1'b0);
        checkOutput("subAcc", 16'(accObs), 16'd0);
        applyStimulus(1'b0);
        checkOutput("jcNotTakenPc", 16'(pcObs), 16'd12);
        applyStimulus(1'b0);
        checkOutput("jzTakenPc", 16'(pcObs), 16'd0);

        // JMP 6; LDI 6; ST 5; LD 5 with address 5 as data.
        $display("[TB] store and load back");
        setImage(64'h8600_00F6_C5B5_8C00);
        doReset(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("stStrobeCount", 16'(lastWrCount), 16'd1);
        checkOutput("stAddr", 16'(lastWrAddr), 16'd5);
        checkOutput("stData", 16'(lastWrData), 16'd6);
        checkOutput("stMemory", 16'(tbMem[5]), 16'd6);
        applyStimulus(1'b0);
        checkOutput("ldAcc", 16'(accObs), 16'd6);

        // Reset asserted while ST is in its memory-access phase.
        $display("[TB] reset during store");
        setImage(64'hF7C9_0000_0000_0000);
        doReset(1'b1);
        applyStimulus(1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("preResetWrEn", 16'(bus.mem_wr_en_o), 16'd1);
        checkOutput("preResetWrAddr", 16'(bus.mem_addr_o), 16'd9);
        resetN = 1'b0;
        #1;
        checkOutput("abortWrEn", 16'(bus.mem_wr_en_o), 16'd0);
        checkOutput("abortPc", 16'(pcObs), 16'd0);
        checkOutput("abortAcc", 16'(accObs), 16'd0);
        checkOutput("abortOutValid", 16'(outValid), 16'd0);
        @(posedge clk);
        #1;
        checkOutput("abortNoWrite", 16'(tbMem[9]), 16'd0);

        // Random programs with random stalls and mid-instruction run drops.
        $display("[TB] random programs");
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 16; a++) progImage[a] = 4'($urandom);
            doReset(1'b1);
            for (int s = 0; s < 50; s++) begin
                stallCycles($urandom_range(0, 3));
                applyStimulus(1'b1);
            end
            for (int a = 0; a < 16; a++) checkOutput("finalMemory", 16'(tbMem[a]), 16'(mMem[a]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Fetch/decode/execute controller for the 4-bit CPU. It sits directly upstream of the 16x4 program/data memory.
- It owns PC, accumulator A, instruction/operand registers and Z/C flags, and drives the memory's address, read-enable and write-enable.
- Memory read data is combinational and is sampled in the same cycle; writes commit on the next clk_i edge.

Parameters:
- DATA_WIDTH, 4, accumulator/memory word width; only 4 supported (ISA encodes 4-bit opcodes).
- ADDR_WIDTH, 4, PC/memory address width; only 4 supported.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- run_i  input  1  1 = may start fetching the next instruction.
- mem_data_i  input  4  memory read data (combinational from mem_addr_o).
- in_data_i  input  4  external input port, sampled by IN.
- mem_addr_o  output  4  memory address.
- mem_rd_en_o  output  1  memory read enable.
- mem_wr_en_o  output  1  memory write enable.
- mem_data_o  output  4  memory write data (= A).
- out_data_o  output  4  output port register.
- out_valid_o  output  1  one-cycle pulse when out_data_o is updated.
- pc_o  output  4  current PC (debug).
- acc_o  output  4  current A (debug).

Behaviour:
- Reset (async, reset_ni=0): state=FETCH, PC=0, A=0, IR=0, OPR=0, MDR=0, Z=0, C=0, out_data_o=0, out_valid_o=0.
- mem_* outputs are combinational decodes of state. In any state or phase not listed as driving them, mem_rd_en_o=0, mem_wr_en_o=0, mem_addr_o=PC.
- ISA:
  - Single nibble: NOP 0, INC 5, DEC 6, IN D, OUT E.
  - Operand nibble follows the opcode: XOR 1, AND 2, OR 3, ADD 4, SUB 7, JMP 8, JZ 9, JC A, LD B, ST C, LDI F.
  - For XOR/AND/OR/ADD/SUB/LD/ST the operand is a direct memory address. For JMP/JZ/JC it is the target. For LDI it is an immediate.
- States:
  - FETCH: if run_i=0, hold (rd_en=0). Else addr=PC, rd_en=1, IR<=mem_data_i, PC<=PC+1. Next state is OPERAND if the fetched opcode takes an operand, else EXEC.
  - OPERAND: addr=PC, rd_en=1, OPR<=mem_data_i, PC<=PC+1. Next state is MEMACC for XOR/AND/OR/ADD/SUB/LD/ST, else EXEC.
  - MEMACC:
    - ST: addr=OPR, wr_en=1, mem_data_o=A; next FETCH.
    - Otherwise: addr=OPR, rd_en=1, MDR<=mem_data_i; next EXEC.
  - EXEC: perform the operation; next FETCH.
- Instruction cycles: NOP/INC/DEC/IN/OUT 2; JMP/JZ/JC/LDI/ST 3; XOR/AND/OR/ADD/SUB/LD 4.
- Arithmetic, all mod 16:
  - ADD: C = carry-out.
  - SUB: A=A-MDR, C=1 iff A<MDR (borrow).
  - INC: C=1 iff A was 15.
  - DEC: C=1 iff A was 0.
  - XOR/AND/OR: C=0.
  - LD/IN/LDI: C unchanged.
- Z = (new A == 0) on every instruction that writes A. Z is unchanged by NOP, JMP, JZ, JC, ST and OUT.
- Jumps: JMP sets PC=OPR. JZ/JC set PC=OPR if Z/C is 1, else PC is left (already past the operand).
- OUT: out_data_o<=A in EXEC; out_valid_o=1 for exactly the following cycle; out_data_o holds until the next OUT.
- PC wraps 15->0, including operand fetch at PC=15.
- run_i is sampled only in FETCH; deassertion mid-instruction does not stall the instruction in progress.
- ST then fetch of the same address: the fetch returns the new value (self-modifying code supported).
- reset_ni low mid-instruction: abort immediately to reset values; no partial write occurs after the reset edge.

Test Plan:
- Memory reset program (OUT, INC, JMP 0), run_i=1 -> out_valid_o pulses every 7 cycles with out_data_o = 0,1,2,...,15,0 (wrap).
- Set A=0 via memory, program LDI 9, ADD @addr holding 8 -> A=1, C=1, Z=0; then SUB @addr holding 1 -> A=0, Z=1, C=0.
- ST 5 followed by LD 5 after LDI 6 -> mem_wr_en_o high exactly 1 cycle with addr=5, data=6; A reads back 6.
- JZ 0 with Z=0 -> PC advances by 2. JZ 0 with Z=1 -> PC=0 after EXEC. Same pair for JC with C.
- run_i=0 after reset -> mem_rd_en_o=0, PC stays 0 for 10 cycles. Raise run_i -> first fetch at address 0 the same cycle.
- Assert reset_ni during MEMACC of an ST -> no write strobe after the reset edge; PC=0, A=0, out_valid_o=0 immediately.
